// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s), paced by the tx bit clock.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense selected by PARITY_ODD).
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_clk,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);
    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_serializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [1:0]           stop_cnt, stop_cnt_nxt;
    logic                 tx_nxt, busy_nxt, done_nxt;
    logic                 prev_tx_clk;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit, parity_nxt;
`endif

    assign tick = i_tx_clk & ~prev_tx_clk;

    always_ff @(posedge i_clk) begin
        prev_tx_clk <= i_tx_clk;
        if (i_rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            o_tx      <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            stop_cnt  <= stop_cnt_nxt;
            o_tx      <= tx_nxt;
            o_tx_busy <= busy_nxt;
            o_tx_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        tx_nxt       = o_tx;
        busy_nxt     = o_tx_busy;
        done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt   = parity_bit;
`endif
        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                // The done cycle still belongs to the finished frame, so a request landing on it is dropped
                if (i_tx_start && !o_tx_done) begin
                    shift_nxt   = i_tx_data;
                    bit_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ARM;
`ifdef UART_TX_PARITY_EN
                    parity_nxt  = (^i_tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            ARM: begin
                if (tick) begin
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_nxt      = shift[0];
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = CNT_W'(1);
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt < CNT_W'(DATA_BITS)) begin
                        tx_nxt      = shift[0];
                        shift_nxt   = shift >> 1;
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt       = parity_bit;
                        state_nxt    = PARITY;
`else
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 2'd1;
                        state_nxt    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 2'd1;
                    state_nxt    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt < 2'(STOP_BITS)) begin
                        stop_cnt_nxt = stop_cnt + 2'd1;
                    end else begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
